// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures retired instructions into a small
// FIFO and streams each record out as four 32-bit words (header, pc, insn,
// rd_wdata). Overflow never stalls the core; lost retirements are counted
// and the next captured record is flagged.
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       trace_en_i,
    input  logic                       rvfi_valid,
    input  logic [63:0]                rvfi_order,
    input  logic [31:0]                rvfi_insn,
    input  logic                       rvfi_trap,
    input  logic                       rvfi_intr,
    input  logic [1:0]                 rvfi_mode,
    input  logic [4:0]                 rvfi_rd_addr,
    input  logic [31:0]                rvfi_rd_wdata,
    input  logic [31:0]                rvfi_pc_rdata,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [31:0]                trace_data_o,
    output logic                       trace_last_o,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic [DropCntWidth-1:0]    drop_cnt_o,
    output logic                       overflow_o,
    input  logic                       clear_i
);

    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned PtrW   = AddrW + 1;
    localparam int unsigned LevelW = $clog2(Depth + 1);

    // One extra pointer bit distinguishes full from empty
    logic [PtrW-1:0]         wr_ptr;
    logic [PtrW-1:0]         rd_ptr;
    logic [PtrW-1:0]         fill;
    logic [1:0]              word_idx;
    logic                    drop_pending;
    logic [DropCntWidth-1:0] drop_cnt;
    logic                    overflow;

    logic [31:0] hdr_mem   [Depth];
    logic [31:0] pc_mem    [Depth];
    logic [31:0] insn_mem  [Depth];
    logic [31:0] wdata_mem [Depth];

    logic        empty;
    logic        full;
    logic        handshake;
    logic        pop;
    logic        retire;
    logic        push;
    logic        drop;
    logic [31:0] header;
    logic [31:0] word;
    logic        unused_order;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                       (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
    assign handshake = ~empty & trace_ready_i;
    assign pop       = handshake & (word_idx == 2'd3);
    assign retire    = trace_en_i & rvfi_valid;
    assign push      = retire & (~full | pop);
    assign drop      = retire & full & ~pop;

    assign header = {rvfi_trap, rvfi_intr, drop_pending, rvfi_rd_addr,
                     rvfi_mode, 6'd0, rvfi_order[15:0]};

    // Only the low 16 bits of the retirement index are recorded
    assign unused_order = ^rvfi_order[63:16];

    assign fill       = wr_ptr - rd_ptr;
    assign level_o    = LevelW'(fill);
    assign drop_cnt_o = drop_cnt;
    assign overflow_o = overflow;

    // Record storage is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            hdr_mem[wr_ptr[AddrW-1:0]]   <= header;
            pc_mem[wr_ptr[AddrW-1:0]]    <= rvfi_pc_rdata;
            insn_mem[wr_ptr[AddrW-1:0]]  <= rvfi_insn;
            wdata_mem[wr_ptr[AddrW-1:0]] <= rvfi_rd_wdata;
        end
    end

    // FIFO pointers and the serializer word index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (handshake) begin
                word_idx <= word_idx + 2'd1;
            end
        end
    end

    // Drop bookkeeping: pending flag, saturating counter and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_pending <= 1'b0;
            drop_cnt     <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push) begin
                drop_pending <= 1'b0;
            end else if (drop) begin
                drop_pending <= 1'b1;
            end
            if (clear_i) begin
                drop_cnt <= drop ? DropCntWidth'(1) : '0;
                overflow <= drop;
            end else if (drop) begin
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DropCntWidth'(1);
                end
                overflow <= 1'b1;
            end
        end
    end

    // Select the current word of the head record; zero when idle
    always_comb begin
        word = 32'd0;
        if (!empty) begin
            case (word_idx)
                2'd0:    word = hdr_mem[rd_ptr[AddrW-1:0]];
                2'd1:    word = pc_mem[rd_ptr[AddrW-1:0]];
                2'd2:    word = insn_mem[rd_ptr[AddrW-1:0]];
                default: word = wdata_mem[rd_ptr[AddrW-1:0]];
            endcase
        end
    end

    assign trace_valid_o = ~empty;
    assign trace_data_o  = word;
    assign trace_last_o  = ~empty & (word_idx == 2'd3);

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Self-checking bench for ibex_rvfi_trace_buffer. A queue-based model of the
// record stream predicts every output each cycle; directed steps add the
// fixed-value checks for single retirement, overflow, saturation and reset.
module tb_ibex_rvfi_trace_buffer;

    localparam int Depth = 8;
    localparam int DropW = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [15:0] order;
        logic [4:0]  rd;
        logic [1:0]  mode;
        logic        trap;
        logic        intr;
    } rec_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              trace_en_i;
    logic              rvfi_valid;
    logic [63:0]       rvfi_order;
    logic [31:0]       rvfi_insn;
    logic              rvfi_trap;
    logic              rvfi_intr;
    logic [1:0]        rvfi_mode;
    logic [4:0]        rvfi_rd_addr;
    logic [31:0]       rvfi_rd_wdata;
    logic [31:0]       rvfi_pc_rdata;
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [31:0]       trace_data_o;
    logic              trace_last_o;
    logic [3:0]        level_o;
    logic [DropW-1:0]  drop_cnt_o;
    logic              overflow_o;
    logic              clear_i;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {header, pc, insn, wdata} records
    logic [127:0] mq[$];
    int unsigned  midx;
    bit           mdp;
    int unsigned  mcnt;
    bit           movf;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_buffer #(
        .Depth        (Depth),
        .DropCntWidth (DropW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .trace_en_i    (trace_en_i),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_intr     (rvfi_intr),
        .rvfi_mode     (rvfi_mode),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .level_o       (level_o),
        .drop_cnt_o    (drop_cnt_o),
        .overflow_o    (overflow_o),
        .clear_i       (clear_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t randRec();
        rec_t r;
        r.pc    = $urandom;
        r.insn  = $urandom;
        r.wdata = $urandom;
        r.order = 16'($urandom);
        r.rd    = 5'($urandom);
        r.mode  = 2'($urandom);
        r.trap  = 1'($urandom);
        r.intr  = 1'($urandom);
        return r;
    endfunction

    task automatic modelReset();
        mq.delete();
        midx = 0;
        mdp  = 0;
        mcnt = 0;
        movf = 0;
    endtask

    // Compare every output against the model's view of the stream
    task automatic checkOutput(input string tag);
        bit          ev;
        logic [127:0] e;
        logic [31:0]  w;
        ev = (mq.size() != 0);
        w  = 32'd0;
        if (ev) begin
            e = mq[0];
            w = e[127 - 32*midx -: 32];
        end
        chk($sformatf("%s.valid", tag), 32'(trace_valid_o), 32'(ev));
        chk($sformatf("%s.data", tag), trace_data_o, w);
        chk($sformatf("%s.last", tag), 32'(trace_last_o), 32'(ev && midx == 3));
        chk($sformatf("%s.level", tag), 32'(level_o), 32'(mq.size()));
        chk($sformatf("%s.drop_cnt", tag), 32'(drop_cnt_o), mcnt);
        chk($sformatf("%s.overflow", tag), 32'(overflow_o), 32'(movf));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic applyStimulus(input string tag, input logic en, input logic vld,
                                 input logic rdy, input logic clr, input rec_t r);
        bit mvalid, mpop, mfull, mpush, mdrop;
        trace_en_i    = en;
        rvfi_valid    = vld;
        trace_ready_i = rdy;
        clear_i       = clr;
        rvfi_pc_rdata = r.pc;
        rvfi_insn     = r.insn;
        rvfi_rd_wdata = r.wdata;
        rvfi_order    = {32'($urandom), 16'($urandom), r.order};
        rvfi_rd_addr  = r.rd;
        rvfi_mode     = r.mode;
        rvfi_trap     = r.trap;
        rvfi_intr     = r.intr;

        mvalid = (mq.size() != 0);
        mpop   = mvalid && rdy && (midx == 3);
        mfull  = (mq.size() == Depth);
        mpush  = en && vld && (!mfull || mpop);
        mdrop  = en && vld && mfull && !mpop;
        if (mvalid && rdy) midx = (midx + 1) % 4;
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
            mq.push_back({r.trap, r.intr, mdp, r.rd, r.mode, 6'd0, r.order,
                          r.pc, r.insn, r.wdata});
            mdp = 0;
        end
        if (mdrop) mdp = 1;
        if (clr) begin
            mcnt = mdrop ? 1 : 0;
            movf = mdrop;
        end else if (mdrop) begin
            if (mcnt < (1 << DropW) - 1) mcnt++;
            movf = 1;
        end

        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput(tag);
    endtask

    task automatic checkAllZero(input string tag);
        chk($sformatf("%s.valid", tag), 32'(trace_valid_o), 32'd0);
        chk($sformatf("%s.data", tag), trace_data_o, 32'd0);
        chk($sformatf("%s.last", tag), 32'(trace_last_o), 32'd0);
        chk($sformatf("%s.level", tag), 32'(level_o), 32'd0);
        chk($sformatf("%s.drop_cnt", tag), 32'(drop_cnt_o), 32'd0);
        chk($sformatf("%s.overflow", tag), 32'(overflow_o), 32'd0);
    endtask

    task automatic drainAll(input string tag);
        rec_t zr;
        zr = '0;
        for (int s = 0; s < 100 && mq.size() != 0; s++) begin
            applyStimulus(tag, 1'b1, 1'b0, 1'b1, 1'b0, zr);
        end
        chk($sformatf("%s.empty", tag), 32'(level_o), 32'd0);
    endtask

    // Hard stop in case something wedges the scheduler
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rec_t        r;
        rec_t        zr;
        int          w;
        int unsigned base;

        zr = '0;
        trace_en_i    = 1'b0;
        rvfi_valid    = 1'b0;
        trace_ready_i = 1'b0;
        clear_i       = 1'b0;
        rvfi_order    = '0;
        rvfi_insn     = '0;
        rvfi_trap     = 1'b0;
        rvfi_intr     = 1'b0;
        rvfi_mode     = '0;
        rvfi_rd_addr  = '0;
        rvfi_rd_wdata = '0;
        rvfi_pc_rdata = '0;
        modelReset();

        // Power-on reset
        #1 rst_ni = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        checkOutput("after_reset");

        // Single retirement with known values
        r = '0;
        r.pc    = 32'h0000_1000;
        r.insn  = 32'h0051_0133;
        r.rd    = 5'd2;
        r.wdata = 32'h0000_00AB;
        r.order = 16'd5;
        applyStimulus("single.push", 1'b1, 1'b1, 1'b1, 1'b0, r);
        chk("single.w0", trace_data_o, 32'h0200_0005);
        chk("single.l0", 32'(trace_last_o), 32'd0);
        applyStimulus("single.s1", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        chk("single.w1", trace_data_o, 32'h0000_1000);
        chk("single.l1", 32'(trace_last_o), 32'd0);
        applyStimulus("single.s2", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        chk("single.w2", trace_data_o, 32'h0051_0133);
        chk("single.l2", 32'(trace_last_o), 32'd0);
        applyStimulus("single.s3", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        chk("single.w3", trace_data_o, 32'h0000_00AB);
        chk("single.l3", 32'(trace_last_o), 32'd1);
        applyStimulus("single.s4", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        chk("single.idle", 32'(trace_valid_o), 32'd0);

        // Overflow: ten retirements into an eight-deep FIFO with no sink
        for (int i = 0; i < 10; i++) begin
            applyStimulus("ovf.fill", 1'b1, 1'b1, 1'b0, 1'b0, randRec());
        end
        chk("ovf.level", 32'(level_o), 32'd8);
        chk("ovf.drop_cnt", 32'(drop_cnt_o), 32'd2);
        chk("ovf.overflow", 32'(overflow_o), 32'd1);

        // Release the sink, push a ninth record once space opens, check drop flags
        w = 0;
        for (int s = 0; s < 80 && w < 36; s++) begin
            if (trace_valid_o) begin
                if (w % 4 == 0) begin
                    chk($sformatf("ovf.hdr%0d.bit29", w / 4), 32'(trace_data_o[29]),
                        32'(w / 4 == 8));
                end
                w++;
            end
            applyStimulus("ovf.drain", 1'b1, (s == 4), 1'b1, 1'b0, randRec());
        end
        chk("ovf.words", 32'(w), 32'd36);
        chk("ovf.drained", 32'(level_o), 32'd0);

        // Full FIFO with a push on the same cycle as the final-word handshake
        for (int i = 0; i < 8; i++) begin
            applyStimulus("fullpop.fill", 1'b1, 1'b1, 1'b0, 1'b0, randRec());
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("fullpop.adv", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        end
        applyStimulus("fullpop.push", 1'b1, 1'b1, 1'b1, 1'b0, randRec());
        chk("fullpop.level", 32'(level_o), 32'd8);
        chk("fullpop.drop_cnt", 32'(drop_cnt_o), 32'd2);

        // Saturating counter, then clear coinciding with a drop, then plain clear
        for (int i = 0; i < 20; i++) begin
            applyStimulus("sat.drop", 1'b1, 1'b1, 1'b0, 1'b0, randRec());
        end
        chk("sat.drop_cnt", 32'(drop_cnt_o), 32'd15);
        applyStimulus("sat.clear_drop", 1'b1, 1'b1, 1'b0, 1'b1, randRec());
        chk("sat.clear_drop.cnt", 32'(drop_cnt_o), 32'd1);
        chk("sat.clear_drop.ovf", 32'(overflow_o), 32'd1);
        applyStimulus("sat.clear", 1'b1, 1'b0, 1'b0, 1'b1, zr);
        chk("sat.clear.cnt", 32'(drop_cnt_o), 32'd0);
        chk("sat.clear.ovf", 32'(overflow_o), 32'd0);

        // Random back-pressure and random retirements
        for (int i = 0; i < 300; i++) begin
            applyStimulus("bp", 1'b1, ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 1'b0, randRec());
        end
        drainAll("bp.drain");

        // Capture disabled: nothing pushed, nothing counted
        base = mcnt;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("en_off.empty", 1'b0, 1'b1, 1'b1, 1'b0, randRec());
        end
        chk("en_off.level", 32'(level_o), 32'd0);
        chk("en_off.drop_cnt", 32'(drop_cnt_o), base);
        for (int i = 0; i < 8; i++) begin
            applyStimulus("en_off.fill", 1'b1, 1'b1, 1'b0, 1'b0, randRec());
        end
        base = mcnt;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("en_off.full", 1'b0, 1'b1, 1'b0, 1'b0, randRec());
        end
        chk("en_off.full.level", 32'(level_o), 32'd8);
        chk("en_off.full.drop_cnt", 32'(drop_cnt_o), base);

        // Reset in the middle of a record
        applyStimulus("rst.mid0", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        applyStimulus("rst.mid1", 1'b1, 1'b0, 1'b1, 1'b0, zr);
        #2 rst_ni = 1'b0;
        #1 checkAllZero("rst.async");
        modelReset();
        @(negedge clk_i);
        checkAllZero("rst.held");
        rst_ni = 1'b1;
        checkOutput("rst.release");
        applyStimulus("rst.push", 1'b1, 1'b1, 1'b1, 1'b0, randRec());
        drainAll("rst.drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
